// File: rtl/pwm_meas_pkg.sv
// Shared types and constants for the PWM capture / duty decoder.
// State encoding, duty width, divider iteration count and band thresholds.
package pwm_meas_pkg;

  localparam int DUTY_W   = 7;
  localparam int DIV_ITER = 7;

  localparam logic [DUTY_W-1:0] BAND0_MIN = 7'd65;
  localparam logic [DUTY_W-1:0] BAND1_MIN = 7'd35;
  localparam logic [DUTY_W-1:0] BAND2_MIN = 7'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MEAS  = 2'd1,
    ST_STUCK = 2'd2
  } state_t;

  // Band 0 is the highest drive level, band 3 the lowest.
  function automatic logic [1:0] band_of(input logic [DUTY_W-1:0] duty);
    if (duty >= BAND0_MIN)      return 2'd0;
    else if (duty >= BAND1_MIN) return 2'd1;
    else if (duty >= BAND2_MIN) return 2'd2;
    else                        return 2'd3;
  endfunction

endpackage

// File: rtl/pwm_meas_div.sv
// Restoring divider, one quotient bit per cycle, DIV_ITER iterations.
// The caller guarantees the quotient fits in DUTY_W bits.
module duty_div
  import pwm_meas_pkg::*;
#(
  parameter int CNT_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [CNT_W+6:0]  i_num,
  input  logic [CNT_W-1:0]  i_den,
  output logic              o_busy,
  output logic              o_done,
  output logic [DUTY_W-1:0] o_quot
);

  logic [CNT_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_den;
  logic [DUTY_W-1:0] r_num_lo;
  logic [DUTY_W-2:0] r_quot;
  logic [2:0]        r_cnt;
  logic              r_busy;

  logic [CNT_W-1:0]  w_trial;
  logic [CNT_W-1:0]  w_rem_next;
  logic              w_ge;

  // r_rem < r_den always, so a set MSB means the shifted trial exceeds r_den;
  // the modular subtraction below is then still exact.
  always_comb begin
    w_trial    = {r_rem[CNT_W-2:0], r_num_lo[DUTY_W-1]};
    w_ge       = r_rem[CNT_W-1] | (w_trial >= r_den);
    w_rem_next = w_ge ? (w_trial - r_den) : w_trial;
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == 3'(DIV_ITER - 1));
  assign o_quot = {r_quot, w_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem    <= '0;
      r_den    <= '0;
      r_num_lo <= '0;
      r_quot   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_rem    <= i_num[CNT_W+6:DUTY_W];
      r_num_lo <= i_num[DUTY_W-1:0];
      r_den    <= i_den;
      r_quot   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_rem    <= w_rem_next;
      r_num_lo <= {r_num_lo[DUTY_W-2:0], 1'b0};
      r_quot   <= {r_quot[DUTY_W-3:0], w_ge};
      r_cnt    <= r_cnt + 3'd1;
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_meas.sv
// PWM capture: measures period and high time rise-to-rise, divides for duty %.
// Optional band decode is built only when PWM_MEAS_BAND_EN is defined.
module pwm_meas
  import pwm_meas_pkg::*;
#(
  parameter int CNT_W   = 11,
  parameter int TIMEOUT = 1500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic              valid,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DUTY_W-1:0] duty_pct,
  output logic              stuck,
  output logic              ovr,
  output logic [1:0]        band,
  output logic [1:0]        dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            r_state, w_state_next;
  logic              r_s1, r_s2, r_prev;
  logic [CNT_W-1:0]  r_period_cnt, r_high_cnt;
  logic [CNT_W-1:0]  r_lat_period, r_lat_high;
  logic              r_valid, r_stuck, r_ovr;
  logic [CNT_W-1:0]  r_period, r_high;
  logic [DUTY_W-1:0] r_duty;

  logic              w_rise, w_timeout, w_complete, w_start, w_discard;
  logic              w_busy, w_done;
  logic [DUTY_W-1:0] w_quot, w_to_duty;
  logic [CNT_W+6:0]  w_num;

  assign w_rise     = r_s2 & ~r_prev;
  // Counter registers TIMEOUT on the next edge; a simultaneous rise wins.
  assign w_timeout  = (r_state != ST_STUCK) && !w_rise &&
                      (r_period_cnt == CNT_W'(TIMEOUT - 1));
  assign w_complete = w_rise && (r_state == ST_MEAS);
  assign w_start    = w_complete && !w_busy;
  assign w_discard  = w_complete && w_busy;
  assign w_num      = (CNT_W+7)'(r_high_cnt) * (CNT_W+7)'(100);
  assign w_to_duty  = r_s2 ? 7'd100 : 7'd0;

  always_comb begin
    w_state_next = r_state;
    if (w_rise)         w_state_next = ST_MEAS;
    else if (w_timeout) w_state_next = ST_STUCK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_prev       <= 1'b0;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_lat_period <= '0;
      r_lat_high   <= '0;
    end else begin
      r_state <= w_state_next;
      r_s1    <= pwm_in;
      r_s2    <= r_s1;
      r_prev  <= r_s2;
      if (w_rise)                       r_period_cnt <= CNT_W'(1);
      else if (r_period_cnt != CNT_MAX) r_period_cnt <= r_period_cnt + CNT_W'(1);
      if (w_rise)                           r_high_cnt <= CNT_W'(1);
      else if (r_s2 && r_high_cnt != CNT_MAX) r_high_cnt <= r_high_cnt + CNT_W'(1);
      if (w_start) begin
        r_lat_period <= r_period_cnt;
        r_lat_high   <= r_high_cnt;
      end
    end
  end

  duty_div #(.CNT_W(CNT_W)) u_div (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_num   (w_num),
    .i_den   (r_period_cnt),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_quot  (w_quot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_period <= '0;
      r_high   <= '0;
      r_duty   <= '0;
      r_stuck  <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_done) begin
        r_valid  <= 1'b1;
        r_period <= r_lat_period;
        r_high   <= r_lat_high;
        r_duty   <= w_quot;
      end else if (w_timeout) begin
        r_valid  <= 1'b1;
        r_period <= '0;
        r_high   <= '0;
        r_duty   <= w_to_duty;
      end
      if (w_rise)         r_stuck <= 1'b0;
      else if (w_timeout) r_stuck <= 1'b1;
      if (w_discard) r_ovr <= 1'b1;
    end
  end

`ifdef PWM_MEAS_BAND_EN
  logic [1:0] r_band;
  always_ff @(posedge clk) begin
    if (rst)            r_band <= 2'd0;
    else if (w_done)    r_band <= band_of(w_quot);
    else if (w_timeout) r_band <= band_of(w_to_duty);
  end
  assign band = r_band;
`else
  assign band = 2'd0;
`endif

  assign valid     = r_valid;
  assign period    = r_period;
  assign high_time = r_high;
  assign duty_pct  = r_duty;
  assign stuck     = r_stuck;
  assign ovr       = r_ovr;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pwm_meas.sv
// Directed bench for pwm_meas: hand-computed results, strobe timing and timeouts.
module tb_pwm_meas;
  import pwm_meas_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm_in;
  logic        valid;
  logic [10:0] period, high_time;
  logic [6:0]  duty_pct;
  logic        stuck, ovr;
  logic [1:0]  band, dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int r_rel;

  typedef struct {
    int cyc; int per; int hi; int duty; int band; int stk;
  } rec_t;
  rec_t vq[$];

  pwm_meas #(.CNT_W(11), .TIMEOUT(1500)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .valid(valid), .period(period),
    .high_time(high_time), .duty_pct(duty_pct), .stuck(stuck), .ovr(ovr),
    .band(band), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // strobe monitor: records every result with the edge count it followed
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      rec_t r;
      r.cyc = cyc; r.per = int'(period); r.hi = int'(high_time);
      r.duty = int'(duty_pct); r.band = int'(band); r.stk = int'(stuck);
      vq.push_back(r);
    end
  end

  function automatic int exp_band(input int d);
`ifdef PWM_MEAS_BAND_EN
    if (d >= 65) return 0;
    if (d >= 35) return 1;
    if (d >= 10) return 2;
    return 3;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input int idx, input int ecyc, input int eper,
                         input int ehi, input int eduty, input int estk);
    if (idx < vq.size()) begin
      chk($sformatf("%s[%0d].cyc", tag, idx), vq[idx].cyc, ecyc);
      chk($sformatf("%s[%0d].period", tag, idx), vq[idx].per, eper);
      chk($sformatf("%s[%0d].high", tag, idx), vq[idx].hi, ehi);
      chk($sformatf("%s[%0d].duty", tag, idx), vq[idx].duty, eduty);
      chk($sformatf("%s[%0d].band", tag, idx), vq[idx].band, exp_band(eduty));
      chk($sformatf("%s[%0d].stuck", tag, idx), vq[idx].stk, estk);
    end else begin
      chk($sformatf("%s[%0d].present", tag, idx), vq.size(), idx + 1);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pwm_in = 1'b0;
    idle(2);
    rst = 1'b0;
    r_rel = cyc;
    vq.delete();
  endtask

  // One PWM period: hi cycles high, then low until tot cycles; k = edge sampling the rise.
  task automatic pwm_cycle(input int hi, input int tot, output int k);
    @(negedge clk);
    pwm_in = 1'b1;
    k = cyc + 1;
    idle(hi);
    pwm_in = 1'b0;
    idle(tot - hi - 1);
  endtask

  int rk[10];
  int ka, kb, kc, n0;

  initial begin
    rst = 1'b1; pwm_in = 1'b0;
    idle(3);
    chk("rst.valid", valid, 0);
    chk("rst.period", period, 0);
    chk("rst.high", high_time, 0);
    chk("rst.duty", duty_pct, 0);
    chk("rst.band", band, 0);
    chk("rst.stuck", stuck, 0);
    chk("rst.ovr", ovr, 0);
    chk("rst.state", dbg_state, 32'(ST_IDLE));

    // 1000/799 x5: results on rises 2..5 at k+9
    do_reset();
    idle(5);
    for (int i = 0; i < 5; i++) pwm_cycle(799, 1000, rk[i]);
    idle(20);
    chk("t1.count", vq.size(), 4);
    for (int i = 0; i < 4; i++) chk_rec("t1", i, rk[i+1] + 9, 1000, 799, 79, 0);
    chk("t1.ovr", ovr, 0);

    // 499 then 199 high in 1000
    do_reset();
    pwm_cycle(499, 1000, rk[0]);
    pwm_cycle(199, 1000, rk[1]);
    pwm_cycle(1, 20, rk[2]);
    chk("t2.count", vq.size(), 2);
    chk_rec("t2", 0, rk[1] + 9, 1000, 499, 49, 0);
    chk_rec("t2", 1, rk[2] + 9, 1000, 199, 19, 0);
    chk("t2.ovr", ovr, 0);

    // held low from reset: single timeout result, then recovery
    do_reset();
    idle(1510);
    chk("t3.count", vq.size(), 1);
    chk_rec("t3", 0, r_rel + 1500, 0, 0, 0, 1);
    chk("t3.stuck", stuck, 1);
    chk("t3.state", dbg_state, 32'(ST_STUCK));
    idle(200);
    chk("t3.no_repeat", vq.size(), 1);
    pwm_cycle(500, 1000, rk[0]);
    chk("t3.stuck_clr", stuck, 0);
    chk("t3.first_rise", vq.size(), 1);
    pwm_cycle(1, 20, rk[1]);
    chk("t3.count2", vq.size(), 2);
    chk_rec("t3", 1, rk[1] + 9, 1000, 500, 50, 0);

    // held high after a rise
    do_reset();
    idle(3);
    @(negedge clk);
    n0 = cyc;
    pwm_in = 1'b1;
    idle(1510);
    chk("t4.count", vq.size(), 1);
    chk_rec("t4", 0, n0 + 1502, 0, 0, 100, 1);
    idle(50);
    chk("t4.no_repeat", vq.size(), 1);
    chk("t4.state", dbg_state, 32'(ST_STUCK));
    pwm_in = 1'b0;

    // period 6: divider busy covers the next rise, so every other sample is dropped
    do_reset();
    for (int i = 0; i < 9; i++) pwm_cycle(3, 6, rk[i]);
    idle(20);
    chk("t5.count", vq.size(), 4);
    for (int j = 0; j < 4; j++) chk_rec("t5", j, rk[2*j+1] + 9, 6, 3, 50, 0);
    chk("t5.ovr", ovr, 1);

    // reset three cycles into a divide
    do_reset();
    pwm_cycle(300, 1000, ka);
    pwm_cycle(300, 1000, kb);
    @(negedge clk);
    pwm_in = 1'b1;
    kc = cyc + 1;
    idle(3);
    pwm_in = 1'b0;
    idle(2);
    chk("t6.pre_count", vq.size(), 1);
    chk("t6.pre_period", period, 1000);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t6.cyc", cyc, kc + 5);
    chk("t6.valid", valid, 0);
    chk("t6.period", period, 0);
    chk("t6.high", high_time, 0);
    chk("t6.duty", duty_pct, 0);
    chk("t6.band", band, 0);
    chk("t6.stuck", stuck, 0);
    chk("t6.ovr", ovr, 0);
    chk("t6.state", dbg_state, 32'(ST_IDLE));
    idle(30);
    chk("t6.lost", vq.size(), 1);
    pwm_cycle(400, 1000, ka);
    chk("t6.first_rise", vq.size(), 1);
    pwm_cycle(1, 20, kb);
    chk("t6.count", vq.size(), 2);
    chk_rec("t6", 1, kb + 9, 1000, 400, 40, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
